// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style CP0 with STATUS/CAUSE/EPC/EHBR, single-level interrupt entry and ERET.
// Define CP0_IRQ_SYNC_EN to pass ir_in through a 2-flop synchronizer before edge detection.
module cp0_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  cp_oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        in_isr
);
  typedef enum logic {IDLE, ISR} state_t;
  state_t state, state_next;
  logic ie, pending, prev, req, rise, st, eret, take, ie_eff;
  logic [31:0] epc, ehbr;
`ifdef CP0_IRQ_SYNC_EN
  logic s1, s2;
  always_ff @(posedge clk) begin
    s1 <= rst ? 1'b0 : ir_in;
    s2 <= rst ? 1'b0 : s1;
  end
  assign req = s2;
`else
  assign req = ir_in;
`endif
  assign rise = req & ~prev;
  assign st = en & (cp_oper == 2'b01);
  assign eret = ~rst & en & (cp_oper == 2'b10);
  // a STORE clearing IE masks entry in the same cycle; a STORE setting IE only takes effect next cycle
  assign ie_eff = ie & ~(st & (addr_w == 5'd12) & ~data_w[0]);
  assign take = ~rst & (state == IDLE) & pending & ie_eff & en & ~eret;
  assign jump_en = eret | take;
  assign jump_addr = eret ? epc : take ? ehbr : 32'd0;
  assign in_isr = ~rst & (state == ISR);
  always_comb begin
    data_r = 32'd0;
    case (addr_r)
      5'd12: data_r = {31'd0, ie};
      5'd13: data_r = {21'd0, pending, 10'd0};
      5'd14: data_r = epc;
      5'd25: data_r = ehbr;
      default: data_r = 32'd0;
    endcase
  end
  always_comb state_next = eret ? IDLE : take ? ISR : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ie      <= 1'b0;
      epc     <= 32'd0;
      ehbr    <= 32'd0;
      pending <= 1'b0;
      prev    <= 1'b0;
    end else begin
      state   <= state_next;
      prev    <= req;
      pending <= take ? 1'b0 : (pending | rise);
      if (st && addr_w == 5'd12) ie <= data_w[0];
      if (take) epc <= ret_addr;
      else if (st && addr_w == 5'd14) epc <= data_w;
      if (st && addr_w == 5'd25) ehbr <= data_w;
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed vectors for cp0_unit in the default (unsynchronized ir_in) build.
module tb_cp0_unit;
  logic        clk = 0, rst = 1, en = 1, ir_in = 0;
  logic [1:0]  cp_oper = 0;
  logic [4:0]  addr_r = 0, addr_w = 0;
  logic [31:0] data_w = 0, ret_addr = 0, data_r, jump_addr;
  logic        jump_en, in_isr;
  int vecs = 0, errs = 0;
  cp0_unit dut (
    .clk(clk), .rst(rst), .en(en), .cp_oper(cp_oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ret_addr(ret_addr), .ir_in(ir_in),
    .jump_en(jump_en), .jump_addr(jump_addr), .in_isr(in_isr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    addr_r = a;
    #1;
    chk(tag, data_r, exp);
  endtask
  task automatic jmp(input string tag, input logic e, input logic [31:0] a);
    #1;
    chk({tag, "_en"}, {31'd0, jump_en}, {31'd0, e});
    chk({tag, "_addr"}, jump_addr, a);
  endtask
  task automatic store(input logic [4:0] a, input logic [31:0] d);
    cp_oper = 2'b01; addr_w = a; data_w = d;
    cyc;
    cp_oper = 2'b00;
  endtask
  task automatic pulse;
    ir_in = 1;
    cyc;
    ir_in = 0;
  endtask
  task automatic eret_out(input string tag, input logic [31:0] epc);
    cp_oper = 2'b10;
    jmp(tag, 1, epc);
    cyc;
    cp_oper = 2'b00;
    #1;
    chk({tag, "_isr"}, {31'd0, in_isr}, 0);
  endtask
  initial begin
    cp_oper = 2'b10;
    cyc; cyc;
    jmp("rst_force", 0, 0);
    chk("rst_isr", {31'd0, in_isr}, 0);
    rst = 0; cp_oper = 0;
    rd(12, "rst_status", 0);
    rd(14, "rst_epc", 0);
    rd(25, "rst_ehbr", 0);
    rd(13, "rst_cause", 0);
    // basic entry
    store(25, 32'h100);
    store(12, 1);
    rd(25, "ehbr_wr", 32'h100);
    rd(12, "status_wr", 1);
    store(5, 32'hffff_ffff);
    rd(5, "unused_reg", 0);
    ret_addr = 32'h24;
    pulse;
    jmp("entry1", 1, 32'h100);
    rd(13, "cause_ip", 32'h400);
    cyc;
    jmp("entry1_after", 0, 0);
    chk("entry1_isr", {31'd0, in_isr}, 1);
    rd(14, "entry1_epc", 32'h24);
    rd(13, "cause_clr", 0);
    // no nesting, then ERET followed by re-entry
    pulse;
    jmp("nonest", 0, 0);
    chk("nonest_isr", {31'd0, in_isr}, 1);
    ret_addr = 32'h30;
    cp_oper = 2'b10;
    jmp("eret1", 1, 32'h24);
    cyc;
    cp_oper = 0;
    chk("eret1_isr", {31'd0, in_isr}, 0);
    jmp("reentry", 1, 32'h100);
    cyc;
    chk("reentry_isr", {31'd0, in_isr}, 1);
    rd(14, "reentry_epc", 32'h30);
    eret_out("exit1", 32'h30);
    // IE=0 keeps the request pending until enabled
    store(12, 0);
    pulse;
    jmp("ie0", 0, 0);
    rd(13, "ie0_cause", 32'h400);
    cp_oper = 2'b01; addr_w = 12; data_w = 1;
    jmp("ie_set_same", 0, 0);
    cyc;
    cp_oper = 0;
    ret_addr = 32'h40;
    jmp("ie_set_next", 1, 32'h100);
    cyc;
    rd(14, "ie_epc", 32'h40);
    eret_out("exit2", 32'h40);
    // ERET wins over a pending interrupt in the same cycle
    pulse;
    cp_oper = 2'b10;
    jmp("eret_prio", 1, 32'h40);
    cyc;
    cp_oper = 0;
    ret_addr = 32'h50;
    jmp("after_eret", 1, 32'h100);
    cyc;
    rd(14, "after_eret_epc", 32'h50);
    eret_out("exit3", 32'h50);
    // en=0 freezes state and suppresses entry
    en = 0;
    pulse;
    ret_addr = 32'h60;
    jmp("en0", 0, 0);
    cp_oper = 2'b01; addr_w = 25; data_w = 32'hdead;
    cyc;
    cp_oper = 0;
    rd(14, "en0_epc", 32'h50);
    rd(25, "en0_store", 32'h100);
    en = 1;
    jmp("en1", 1, 32'h100);
    cyc;
    rd(14, "en1_epc", 32'h60);
    eret_out("exit4", 32'h60);
    // entry EPC capture beats a STORE to EPC
    pulse;
    ret_addr = 32'h70;
    cp_oper = 2'b01; addr_w = 14; data_w = 32'h777;
    jmp("st_epc_take", 1, 32'h100);
    cyc;
    cp_oper = 0;
    rd(14, "st_epc_lose", 32'h70);
    eret_out("exit5", 32'h70);
    // STORE clearing IE blocks entry that cycle
    pulse;
    cp_oper = 2'b01; addr_w = 12; data_w = 0;
    jmp("ie_clr_block", 0, 0);
    cyc;
    cp_oper = 0;
    rd(13, "ie_clr_pend", 32'h400);
    jmp("ie_clr_after", 0, 0);
    store(12, 1);
    ret_addr = 32'h80;
    // reset during the entry cycle
    rst = 1;
    jmp("rst_entry", 0, 0);
    cyc;
    rst = 0;
    #1;
    chk("rst_entry_isr", {31'd0, in_isr}, 0);
    rd(14, "rst_entry_epc", 0);
    rd(13, "rst_entry_cause", 0);
    jmp("rst_entry_after", 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
